// File: rtl/vector_reducer.sv
// vector_reducer: reduces an INPUT_COUNT-element signed vector to OUTPUT_COUNT
// elements by processing one captured element per clock.
// Build option: define VECTOR_REDUCER_AVG_EN for average pooling over each
// window; leave it undefined for decimation (first element of each window).
module vector_reducer #(
    parameter int unsigned INPUT_COUNT  = 256,
    parameter int unsigned OUTPUT_COUNT = 128,
    parameter int unsigned DATA_WIDTH   = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [DATA_WIDTH*INPUT_COUNT-1:0]  vector_in,
    output logic [DATA_WIDTH*OUTPUT_COUNT-1:0] vector_out,
    output logic                               busy,
    output logic                               done
);

    localparam int unsigned OUT_DIV = (OUTPUT_COUNT == 0) ? 1 : OUTPUT_COUNT;
    localparam int unsigned RATIO   = INPUT_COUNT / OUT_DIV;
    localparam int unsigned CNT_W   = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1;
    localparam bit          CFG_BAD = (OUTPUT_COUNT == 0) || (OUTPUT_COUNT > INPUT_COUNT) ||
                                      ((INPUT_COUNT % OUT_DIV) != 0) || (RATIO == 0) ||
                                      ((RATIO & (RATIO - 1)) != 0);
`ifdef VECTOR_REDUCER_AVG_EN
    localparam int unsigned LOG2R   = (RATIO > 1) ? $clog2(RATIO) : 0;
    localparam int unsigned ACC_W   = DATA_WIDTH + LOG2R;
    localparam int unsigned LAST    = INPUT_COUNT - 1;
`else
    localparam int unsigned LAST    = OUTPUT_COUNT - 1;
`endif

    // Reject geometries where the windows are not equal power-of-two slices
    if (CFG_BAD) begin : g_cfg_err
        $error("vector_reducer: OUTPUT_COUNT must divide INPUT_COUNT with a power-of-two ratio");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                          state;
    logic [CNT_W-1:0]                cnt;
    logic [DATA_WIDTH*INPUT_COUNT-1:0] data_buf;

    int unsigned                     rd_idx_c;
    int unsigned                     wr_idx_c;
    logic                            win_end_c;
    logic signed [DATA_WIDTH-1:0]    elem_c;
    logic signed [DATA_WIDTH-1:0]    wr_data_c;

`ifdef VECTOR_REDUCER_AVG_EN
    logic signed [ACC_W-1:0]         acc;
    logic signed [ACC_W-1:0]         sum_c;

    // Running window sum; the window's mean is taken by arithmetic shift
    always_comb begin
        rd_idx_c  = 32'(cnt);
        elem_c    = data_buf[rd_idx_c*DATA_WIDTH +: DATA_WIDTH];
        sum_c     = acc + ACC_W'(elem_c);
        win_end_c = ((rd_idx_c & (RATIO - 1)) == (RATIO - 1));
        wr_idx_c  = rd_idx_c >> LOG2R;
        wr_data_c = DATA_WIDTH'(sum_c >>> LOG2R);
    end
`else
    // Decimation: counter walks outputs, reading the first element of each window
    always_comb begin
        rd_idx_c  = 32'(cnt) * RATIO;
        elem_c    = data_buf[rd_idx_c*DATA_WIDTH +: DATA_WIDTH];
        win_end_c = 1'b1;
        wr_idx_c  = 32'(cnt);
        wr_data_c = elem_c;
    end
`endif

    // Control FSM, input capture, accumulation and output writeback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            data_buf   <= '0;
            vector_out <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef VECTOR_REDUCER_AVG_EN
            acc        <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        data_buf <= vector_in;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
`ifdef VECTOR_REDUCER_AVG_EN
                        acc      <= '0;
`endif
                    end
                end
                RUN: begin
`ifdef VECTOR_REDUCER_AVG_EN
                    acc <= win_end_c ? '0 : sum_c;
`endif
                    if (win_end_c) begin
                        vector_out[wr_idx_c*DATA_WIDTH +: DATA_WIDTH] <= wr_data_c;
                    end
                    if (cnt == CNT_W'(LAST)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/vector_reducer.md
VECTOR_REDUCER -- requirements
Module: vector_reducer

Interface
REQ-001 SHALL provide parameter INPUT_COUNT, default 256, number of DATA_WIDTH elements in vector_in.
REQ-002 SHALL provide parameter OUTPUT_COUNT, default 128, number of DATA_WIDTH elements in vector_out.
REQ-003 SHALL provide parameter DATA_WIDTH, default 16, signed two's-complement element width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  request to reduce vector_in; sampled on clk.
REQ-008 vector_in  input  DATA_WIDTH*INPUT_COUNT  source vector; element i at bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH].
REQ-009 vector_out  output  DATA_WIDTH*OUTPUT_COUNT  reduced vector; element o packed the same way.
REQ-010 busy  output  1  high while a reduction is in progress.
REQ-011 done  output  1  single-cycle completion pulse.

Function
REQ-012 RATIO = INPUT_COUNT/OUTPUT_COUNT; OUTPUT_COUNT shall be at most INPUT_COUNT, shall divide INPUT_COUNT exactly, and RATIO shall be a power of two. Any violation shall raise a simulation-only $error.
REQ-013 Output element o SHALL be derived from the window vector_in[o*RATIO .. o*RATIO+RATIO-1].
REQ-014 Control SHALL use states IDLE and RUN:
- IDLE->RUN on start=1; RUN->IDLE after the final output element is written.
- On IDLE->RUN, vector_in SHALL be captured into an internal buffer, and busy SHALL go to 1.
REQ-015 start SHALL be ignored while in RUN; changes to vector_in after capture SHALL NOT affect results.
REQ-016 In RUN, one buffer element SHALL be processed per clock, in ascending index order.
REQ-017 vector_out element o SHALL be written only when its window completes; all other elements SHALL hold their previous values.
REQ-018 Timing: if start is accepted at edge k, done SHALL be 1 for exactly the cycle following edge k+L, and busy SHALL fall at that same edge. L is defined in REQ-026 and REQ-027.
REQ-019 A start asserted while done=1 SHALL be accepted, allowing back-to-back operation with no idle gap.
REQ-020 When RATIO=1, the block SHALL copy vector_in to vector_out element-wise in both configurations.

Reset
REQ-021 While rst_n=0, the following SHALL be cleared immediately, regardless of clk:
- vector_out, busy, done and the state (IDLE);
- the element counter, accumulator and input buffer.
REQ-022 If reset is asserted mid-operation, the reduction SHALL be abandoned, no done pulse SHALL be issued, and the next start SHALL begin a fresh reduction.
REQ-023 After rst_n rises, the first rising clk edge SHALL sample start normally.

Configuration
REQ-024 The macro VECTOR_REDUCER_AVG_EN SHALL select the reduction mode.
REQ-025 The accumulator SHALL exist only when VECTOR_REDUCER_AVG_EN is defined.
REQ-026 With VECTOR_REDUCER_AVG_EN defined (average pooling):
- Elements SHALL be summed in a signed accumulator of DATA_WIDTH+log2(RATIO) bits, which cannot overflow.
- The output SHALL be the sum arithmetically shifted right by log2(RATIO), i.e. floor toward negative infinity.
- The accumulator SHALL clear at the start of each window.
- L = INPUT_COUNT.
REQ-027 Without VECTOR_REDUCER_AVG_EN (decimation):
- Output element o SHALL equal vector_in[o*RATIO].
- One output element SHALL be written per clock.
- L = OUTPUT_COUNT.

Verification (INPUT_COUNT=8, OUTPUT_COUNT=4, DATA_WIDTH=16)
REQ-028 AVG_EN, vector_in = 1,2,...,8, start pulsed once -> vector_out = 1,3,5,7; done high for exactly 1 cycle, 8 cycles after the start edge.
REQ-029 AVG_EN, input pairs (-3,-4), (0x7FFF,0x7FFF), (0x8000,0x8000), (-1,0) -> outputs -4, 0x7FFF, 0x8000, -1.
REQ-030 No AVG_EN, vector_in = 1,2,...,8 -> vector_out = 1,3,5,7; done 4 cycles after the start edge.
REQ-031 start held high and vector_in changed during RUN -> exactly one reduction of the captured data; a second start in the done cycle -> a second reduction completes L cycles later.
REQ-032 rst_n pulsed low at cycle 3 of RUN -> vector_out=0, busy=0, and no done pulse; a subsequent start produces correct results.
